// File: rtl/sum_accumulator_if.sv
// sum_accumulator_if: input beat and output result handshakes of sum_accumulator (out_sat exists only with ACC_SAT_EN)
interface sum_accumulator_if #(
    parameter int SWIDTH = 9,
    parameter int AWIDTH = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [SWIDTH-1:0] sum0;
    logic [SWIDTH-1:0] sum1;
    logic              out_valid;
    logic              out_ready;
    logic [AWIDTH-1:0] out_sum;
    logic              out_zero;
    logic [7:0]        beat_cnt;
`ifdef ACC_SAT_EN
    logic              out_sat;
`endif

    modport master (
        output in_valid, sum0, sum1, out_ready,
        input  in_ready, out_valid, out_sum, out_zero, beat_cnt
`ifdef ACC_SAT_EN
        , input out_sat
`endif
    );

    modport slave (
        input  in_valid, sum0, sum1, out_ready,
        output in_ready, out_valid, out_sum, out_zero, beat_cnt
`ifdef ACC_SAT_EN
        , output out_sat
`endif
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT beats of sum0+sum1 into one frame total; ACC_SAT_EN selects saturating adds and out_sat
module sum_accumulator #(
    parameter int SWIDTH = 9,
    parameter int COUNT  = 4,
    parameter int AWIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    sum_accumulator_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t            state, state_d;
    logic [AWIDTH-1:0] acc, acc_d, out_sum, out_sum_d, res;
    logic [7:0]        cnt, cnt_d;
    logic              out_valid, out_valid_d, out_zero, out_zero_d, take, last;
`ifdef ACC_SAT_EN
    localparam int WW = (AWIDTH > SWIDTH ? AWIDTH : SWIDTH) + 2;
    logic [WW-1:0]     sum_w;
    logic              sat_hit, frame_sat, frame_sat_d, out_sat, out_sat_d;
`endif

    assign bus.in_ready  = (state != HOLD) | bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_zero  = out_zero;
    assign bus.beat_cnt  = cnt;
`ifdef ACC_SAT_EN
    assign bus.out_sat   = out_sat;
`endif

    // acc is zero outside ACCUM, so acc + beat sum serves the first, middle and final beat alike
`ifdef ACC_SAT_EN
    always_comb begin
        sum_w   = WW'(acc) + WW'(bus.sum0) + WW'(bus.sum1);
        sat_hit = |sum_w[WW-1:AWIDTH];
        res     = sat_hit ? '1 : sum_w[AWIDTH-1:0];
    end
`else
    always_comb res = acc + AWIDTH'(bus.sum0) + AWIDTH'(bus.sum1);
`endif

    assign take = bus.in_valid & bus.in_ready & ~flush;
    assign last = cnt == 8'(COUNT - 1);

    // next state: output handshake first, then flush (which never touches a pending result) or beat acceptance
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        out_sum_d   = out_sum;
        out_zero_d  = out_zero;
`ifdef ACC_SAT_EN
        frame_sat_d = frame_sat;
        out_sat_d   = out_sat;
`endif
        if (state == HOLD && bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
            if (state != HOLD) state_d = IDLE;
`ifdef ACC_SAT_EN
            frame_sat_d = 1'b0;
`endif
        end else if (take) begin
            if (last) begin
                out_sum_d   = res;
                out_zero_d  = res == '0;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                state_d     = HOLD;
`ifdef ACC_SAT_EN
                out_sat_d   = frame_sat | sat_hit;
                frame_sat_d = 1'b0;
`endif
            end else begin
                acc_d   = res;
                cnt_d   = cnt + 8'd1;
                state_d = ACCUM;
`ifdef ACC_SAT_EN
                frame_sat_d = (cnt == 8'd0) ? sat_hit : (frame_sat | sat_hit);
`endif
            end
        end
    end

    // state and datapath registers; reset drops any partial frame and pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_zero  <= 1'b0;
`ifdef ACC_SAT_EN
            frame_sat <= 1'b0;
            out_sat   <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            out_valid <= out_valid_d;
            out_sum   <= out_sum_d;
            out_zero  <= out_zero_d;
`ifdef ACC_SAT_EN
            frame_sat <= frame_sat_d;
            out_sat   <= out_sat_d;
`endif
        end
    end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the multi-adder.
- Consumes the two registered lane sums (sum0, sum1) under a valid/ready handshake and accumulates COUNT accepted beats into one frame total.
- Presents the total with a zero flag on an output valid/ready handshake.
- Feeds the next consumer (stats/report logic) one result per COUNT input beats.

Parameters:
- SWIDTH, 9: width of each incoming lane sum.
- COUNT, 4: beats per frame; legal range 2..256.
- AWIDTH, 12: accumulator/result width. The default holds 2*(2^SWIDTH-1)*COUNT without overflow.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear; discards any partial frame.
- in_valid  input  1  sum0/sum1 valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- sum0  input  SWIDTH  lane 0 sum, unsigned.
- sum1  input  SWIDTH  lane 1 sum, unsigned.
- out_valid  output  1  out_sum/out_zero hold a completed frame.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  AWIDTH  frame total, unsigned.
- out_zero  output  1  out_sum == 0.
- beat_cnt  output  8  beats accepted in the current frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, beat_cnt=0, out_valid=0, out_sum=0, out_zero=0.
  - Reset asserted mid-frame or mid-HOLD discards everything; no output is produced for that frame.
- Accepted beat: in_valid & in_ready.
- in_ready = (state != HOLD) | out_ready. This is a combinational path from out_ready.
- Beat sum: sum0 + sum1, zero-extended to AWIDTH.
- States and transitions:
  - IDLE: acc=0, beat_cnt=0.
    - Accepted beat -> acc=beat sum, beat_cnt=1, go to ACCUM.
  - ACCUM:
    - Accepted beat with beat_cnt < COUNT-1 -> acc += beat sum, beat_cnt++.
    - Accepted beat with beat_cnt == COUNT-1 -> out_sum = acc + beat sum, out_zero = (that value == 0), out_valid=1 next cycle, acc=0, beat_cnt=0, go to HOLD.
  - HOLD: out_sum/out_zero held stable while out_valid=1 and out_ready=0.
    - out_ready=1 -> out_valid=0 next cycle, go to IDLE.
    - If a beat is accepted in that same cycle, it becomes beat 1 of the new frame: acc=beat sum, beat_cnt=1, go to ACCUM.
- Latency: out_valid rises 1 cycle after the COUNT-th accepted beat. Full throughput is one frame per COUNT cycles when out_ready is held high.
- in_valid=0 cycles are bubbles; state and acc are unchanged.
- flush (ACCUM or IDLE): acc=0, beat_cnt=0, go to IDLE. A beat presented in the flush cycle is dropped; in_ready still reads per the formula, but flush wins.
- flush in HOLD: the pending result is retained (out_valid stays 1). Only the partial accumulation state is cleared.
- Arithmetic:
  - Unsigned.
  - Wraps modulo 2^AWIDTH when ACC_SAT_EN is undefined.
- out_zero is registered together with out_sum and is never computed from a stale value.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined:
  - Every add (first beat, accumulate, final) saturates at 2^AWIDTH-1.
  - A sticky internal flag marks a saturated frame.
  - An extra output port out_sat (1 bit, reset 0) is registered alongside out_sum and cleared at the start of each frame.
- Undefined:
  - Adds wrap modulo 2^AWIDTH.
  - No out_sat port exists.

Test Plan:
- Frame sum, result held: COUNT=4; 4 beats sum0=10,sum1=20 back-to-back, out_ready=0 -> 1 cycle after beat 4, out_valid=1, out_sum=120, out_zero=0; in_ready=0 and out_sum held until out_ready=1.
- Max values, no overflow: beats 511/511 x4 -> out_sum=4088. With ACC_SAT_EN and AWIDTH=11 -> out_sum=2047, out_sat=1. Without ACC_SAT_EN and AWIDTH=11 -> out_sum=4088 mod 2048=2040.
- All-zero frame with bubbles: all-zero beats with in_valid gaps of 0-3 cycles -> out_sum=0, out_zero=1; beat_cnt steps 1,2,3,0 only on accepted beats.
- Back-to-back frames: out_ready=1 held, 8 continuous beats of 1/1 -> two results of 8, each 1 cycle after its 4th beat; no beat lost at the HOLD->ACCUM boundary.
- Flush mid-frame: flush after 2 beats of 5/5, then 4 beats of 1/2 -> out_sum=12. Flush during HOLD -> pending result is still delivered unchanged.
- Reset mid-operation: rst_n pulsed low mid-ACCUM and again in HOLD -> all outputs 0 immediately (asynchronous); the next full frame produces the correct sum.
